// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: byte/half/word loads and stores over a req/ack data port,
// branch/jump redirect resolution and the registered MEM/WB payload.
module mem_access_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] ALU_result,
  input  logic [31:0] Rdata2,
  input  logic [4:0]  Rd,
  input  logic [31:0] PC,
  input  logic        jump_flag,
  input  logic [31:0] jump_target_PC,
  input  logic        branch_op,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic        reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        out_valid,
  output logic [4:0]  wb_Rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic        redirect_valid,
  output logic [31:0] redirect_PC,
  output logic        misalign_fault
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      r_state, w_nextState;

  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [4:0]  r_Rd;
  logic        r_regWrite;
  logic        r_isLoad;
  logic        r_req;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_outValid;
  logic [4:0]  r_wbRd;
  logic        r_wbRegWrite;
  logic [31:0] r_wbData;
  logic        r_redirValid;
  logic [31:0] r_redirPC;
  logic        r_fault;

  logic        w_accept;
  logic        w_isMem;
  logic        w_misalign;
  logic        w_startMem;
  logic        w_direct;
  logic        w_taken;
  logic        w_ack;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_loadData;

  assign w_accept   = in_valid & (r_state == IDLE);
  assign w_isMem    = mem_read | mem_write;
  assign w_startMem = w_accept & w_isMem & ~w_misalign;
  assign w_direct   = w_accept & ~(w_isMem & ~w_misalign);
  assign w_taken    = jump_flag | (branch_op & ALU_result[0]);
  assign w_ack      = (r_state == BUSY) & dmem_ack;

  always_comb begin
    w_misalign = 1'b0;
    w_be       = 4'b1111;
    w_wdata    = Rdata2;
    case (mem_size)
      2'b00: begin
        w_misalign = 1'b0;
        w_be       = 4'b0001 << ALU_result[1:0];
        w_wdata    = {4{Rdata2[7:0]}};
      end
      2'b01: begin
        w_misalign = ALU_result[0];
        w_be       = 4'b0011 << ALU_result[1:0];
        w_wdata    = {2{Rdata2[15:0]}};
      end
      default: begin
        w_misalign = |ALU_result[1:0];
        w_be       = 4'b1111;
        w_wdata    = Rdata2;
      end
    endcase
  end

  // Lane select uses the latched address, since ALU_result may have moved on.
  always_comb begin
    w_byte = dmem_rdata[7:0];
    case (r_addr[1:0])
      2'b00:   w_byte = dmem_rdata[7:0];
      2'b01:   w_byte = dmem_rdata[15:8];
      2'b10:   w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_size)
      2'b00:   w_loadData = r_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_loadData = r_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_loadData = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_startMem) w_nextState = BUSY;
      BUSY:    if (dmem_ack)   w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_size       <= '0;
      r_unsigned   <= 1'b0;
      r_Rd         <= '0;
      r_regWrite   <= 1'b0;
      r_isLoad     <= 1'b0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_be         <= '0;
      r_wdata      <= '0;
      r_outValid   <= 1'b0;
      r_wbRd       <= '0;
      r_wbRegWrite <= 1'b0;
      r_wbData     <= '0;
      r_redirValid <= 1'b0;
      r_redirPC    <= '0;
      r_fault      <= 1'b0;
    end else begin
      r_outValid   <= 1'b0;
      r_redirValid <= 1'b0;
      r_fault      <= 1'b0;
      if (w_startMem) begin
        r_addr     <= ALU_result;
        r_size     <= mem_size;
        r_unsigned <= mem_unsigned;
        r_Rd       <= Rd;
        r_regWrite <= reg_write;
        r_isLoad   <= mem_read;
        r_req      <= 1'b1;
        r_we       <= mem_write;
        r_be       <= w_be;
        r_wdata    <= w_wdata;
      end else if (w_direct) begin
        r_outValid   <= 1'b1;
        r_wbRd       <= Rd;
        r_wbRegWrite <= reg_write & ~(w_isMem & w_misalign);
        r_wbData     <= jump_flag ? (PC + 32'd4) : ALU_result;
        r_redirValid <= w_taken;
        if (w_taken) r_redirPC <= jump_target_PC;
        r_fault      <= w_isMem & w_misalign;
      end else if (w_ack) begin
        r_req        <= 1'b0;
        r_we         <= 1'b0;
        r_outValid   <= 1'b1;
        r_wbRd       <= r_Rd;
        r_wbRegWrite <= r_regWrite;
        r_wbData     <= r_isLoad ? w_loadData : r_addr;
      end
    end
  end

  assign in_ready       = (r_state == IDLE);
  assign dmem_req       = r_req;
  assign dmem_we        = r_we;
  assign dmem_addr      = {r_addr[31:2], 2'b00};
  assign dmem_be        = r_be;
  assign dmem_wdata     = r_wdata;
  assign out_valid      = r_outValid;
  assign wb_Rd          = r_wbRd;
  assign wb_reg_write   = r_wbRegWrite;
  assign wb_data        = r_wbData;
  assign redirect_valid = r_redirValid;
  assign redirect_PC    = r_redirPC;
  assign misalign_fault = r_fault;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a vector table for single-cycle ops plus
// hand-written sequences for memory handshakes and reset during BUSY.
module tb_mem_access_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] ALU_result;
  logic [31:0] Rdata2;
  logic [4:0]  Rd;
  logic [31:0] PC;
  logic        jump_flag;
  logic [31:0] jump_target_PC;
  logic        branch_op;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic        reg_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        out_valid;
  logic [4:0]  wb_Rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic        redirect_valid;
  logic [31:0] redirect_PC;
  logic        misalign_fault;

  int checks = 0;
  int failures = 0;

  mem_access_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ALU_result(ALU_result), .Rdata2(Rdata2), .Rd(Rd), .PC(PC),
    .jump_flag(jump_flag), .jump_target_PC(jump_target_PC), .branch_op(branch_op),
    .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .reg_write(reg_write),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .out_valid(out_valid), .wb_Rd(wb_Rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .redirect_valid(redirect_valid), .redirect_PC(redirect_PC), .misalign_fault(misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] target;
    logic [4:0]  rd;
    logic        jump;
    logic        branch;
    logic        mread;
    logic        mwrite;
    logic [1:0]  size;
    logic        regw;
    logic        chkData;
    logic [31:0] expWb;
    logic        expRw;
    logic        expRedir;
    logic [31:0] expRedirPc;
    logic        expFault;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clearInputs();
    in_valid = 0; ALU_result = 0; Rdata2 = 0; Rd = 0; PC = 0;
    jump_flag = 0; jump_target_PC = 0; branch_op = 0; mem_read = 0;
    mem_write = 0; mem_size = 0; mem_unsigned = 0; reg_write = 0;
  endtask

  task automatic applyStimulus(input vec_t v);
    in_valid = 1; ALU_result = v.alu; PC = v.pc; jump_target_PC = v.target;
    Rd = v.rd; jump_flag = v.jump; branch_op = v.branch; mem_read = v.mread;
    mem_write = v.mwrite; mem_size = v.size; reg_write = v.regw;
    Rdata2 = 32'h5555_5555; mem_unsigned = 0;
  endtask

  // Caller is at a negedge; leaves the bench at the negedge after writeback.
  task automatic runMemAccess(input string name, input logic [31:0] alu, input logic [31:0] st,
                              input logic [1:0] size, input logic uns, input logic [4:0] rd,
                              input logic isLoad, input logic regw, input logic ackEarly,
                              input int ackDelay, input logic [31:0] rdata,
                              input logic [31:0] expAddr, input logic [3:0] expBe,
                              input logic [31:0] expWdata, input logic [31:0] expWb);
    clearInputs();
    in_valid = 1; ALU_result = alu; Rdata2 = st; mem_size = size; mem_unsigned = uns;
    Rd = rd; mem_read = isLoad; mem_write = ~isLoad; reg_write = regw;
    dmem_rdata = rdata;
    dmem_ack = ackEarly;
    @(negedge clk);
    clearInputs();
    checkOutput({name, " req"}, {31'b0, dmem_req}, 32'd1);
    checkOutput({name, " we"}, {31'b0, dmem_we}, {31'b0, ~isLoad});
    checkOutput({name, " addr"}, dmem_addr, expAddr);
    checkOutput({name, " be"}, {28'b0, dmem_be}, {28'b0, expBe});
    if (!isLoad) checkOutput({name, " wdata"}, dmem_wdata, expWdata);
    checkOutput({name, " in_ready busy"}, {31'b0, in_ready}, 32'd0);
    checkOutput({name, " no early out_valid"}, {31'b0, out_valid}, 32'd0);
    for (int d = 0; d < ackDelay; d++) begin
      @(negedge clk);
      checkOutput({name, " req held"}, {31'b0, dmem_req}, 32'd1);
      checkOutput({name, " in_ready wait"}, {31'b0, in_ready}, 32'd0);
    end
    dmem_ack = 1;
    @(negedge clk);
    dmem_ack = 0;
    checkOutput({name, " out_valid"}, {31'b0, out_valid}, 32'd1);
    checkOutput({name, " req dropped"}, {31'b0, dmem_req}, 32'd0);
    checkOutput({name, " in_ready back"}, {31'b0, in_ready}, 32'd1);
    checkOutput({name, " wb_Rd"}, {27'b0, wb_Rd}, {27'b0, rd});
    checkOutput({name, " wb_reg_write"}, {31'b0, wb_reg_write}, {31'b0, regw});
    checkOutput({name, " fault"}, {31'b0, misalign_fault}, 32'd0);
    if (isLoad) checkOutput({name, " wb_data"}, wb_data, expWb);
    @(negedge clk);
    checkOutput({name, " out_valid pulse"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{"alu", 32'h0000_1234, 32'h0, 32'h0, 5'd5, 0, 0, 0, 0, 2'b10, 1,
                1, 32'h0000_1234, 1, 0, 32'h0, 0};
    vecs[1] = '{"lw_misalign", 32'h0000_0101, 32'h0, 32'h0, 5'd3, 0, 0, 1, 0, 2'b10, 1,
                0, 32'h0, 0, 0, 32'h0, 1};
    vecs[2] = '{"br_taken", 32'h0000_0001, 32'h10, 32'h0000_0400, 5'd0, 0, 1, 0, 0, 2'b00, 0,
                1, 32'h0000_0001, 0, 1, 32'h0000_0400, 0};
    vecs[3] = '{"br_not_taken", 32'h0000_0000, 32'h14, 32'h0000_0800, 5'd0, 0, 1, 0, 0, 2'b00, 0,
                1, 32'h0, 0, 0, 32'h0, 0};
    vecs[4] = '{"jal", 32'h0000_0999, 32'h0000_0080, 32'h0000_0200, 5'd1, 1, 0, 0, 0, 2'b00, 1,
                1, 32'h0000_0084, 1, 1, 32'h0000_0200, 0};
    vecs[5] = '{"lh_misalign", 32'h0000_0201, 32'h0, 32'h0, 5'd9, 0, 0, 1, 0, 2'b01, 1,
                0, 32'h0, 0, 0, 32'h0, 1};
    vecs[6] = '{"jal_wrap", 32'h0, 32'hFFFF_FFFC, 32'h0000_0040, 5'd2, 1, 0, 0, 0, 2'b00, 1,
                1, 32'h0000_0000, 1, 1, 32'h0000_0040, 0};
    vecs[7] = '{"sw11_misalign", 32'h0000_0102, 32'h0, 32'h0, 5'd4, 0, 0, 0, 1, 2'b11, 0,
                0, 32'h0, 0, 0, 32'h0, 1};

    clearInputs();
    dmem_ack = 0;
    dmem_rdata = 0;
    rst_n = 1;
    #1 rst_n = 0;
    #1;
    checkOutput("rst in_ready", {31'b0, in_ready}, 32'd1);
    checkOutput("rst dmem_req", {31'b0, dmem_req}, 32'd0);
    checkOutput("rst dmem_we", {31'b0, dmem_we}, 32'd0);
    checkOutput("rst dmem_be", {28'b0, dmem_be}, 32'd0);
    checkOutput("rst dmem_addr", dmem_addr, 32'd0);
    checkOutput("rst dmem_wdata", dmem_wdata, 32'd0);
    checkOutput("rst out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst redirect_valid", {31'b0, redirect_valid}, 32'd0);
    checkOutput("rst redirect_PC", redirect_PC, 32'd0);
    checkOutput("rst misalign_fault", {31'b0, misalign_fault}, 32'd0);
    checkOutput("rst wb_reg_write", {31'b0, wb_reg_write}, 32'd0);
    checkOutput("rst wb_data", wb_data, 32'd0);
    checkOutput("rst wb_Rd", {27'b0, wb_Rd}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Back-to-back single-cycle ops: each vector's result is checked while the next is driven.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput({vecs[i].name, " out_valid"}, {31'b0, out_valid}, 32'd1);
      checkOutput({vecs[i].name, " in_ready"}, {31'b0, in_ready}, 32'd1);
      checkOutput({vecs[i].name, " no req"}, {31'b0, dmem_req}, 32'd0);
      checkOutput({vecs[i].name, " wb_reg_write"}, {31'b0, wb_reg_write}, {31'b0, vecs[i].expRw});
      checkOutput({vecs[i].name, " wb_Rd"}, {27'b0, wb_Rd}, {27'b0, vecs[i].rd});
      checkOutput({vecs[i].name, " redirect_valid"}, {31'b0, redirect_valid}, {31'b0, vecs[i].expRedir});
      checkOutput({vecs[i].name, " misalign_fault"}, {31'b0, misalign_fault}, {31'b0, vecs[i].expFault});
      if (vecs[i].chkData) checkOutput({vecs[i].name, " wb_data"}, wb_data, vecs[i].expWb);
      if (vecs[i].expRedir) checkOutput({vecs[i].name, " redirect_PC"}, redirect_PC, vecs[i].expRedirPc);
    end
    clearInputs();
    @(negedge clk);
    checkOutput("idle out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("idle redirect_valid", {31'b0, redirect_valid}, 32'd0);

    runMemAccess("lb", 32'h0000_0103, 32'h0, 2'b00, 0, 5'd7, 1, 1, 0, 2, 32'h80FF_FF00,
                 32'h0000_0100, 4'b1000, 32'h0, 32'hFFFF_FF80);
    runMemAccess("lbu", 32'h0000_0103, 32'h0, 2'b00, 1, 5'd8, 1, 1, 0, 2, 32'h80FF_FF00,
                 32'h0000_0100, 4'b1000, 32'h0, 32'h0000_0080);
    runMemAccess("sh", 32'h0000_0202, 32'hAAAA_BEEF, 2'b01, 0, 5'd0, 0, 0, 1, 0, 32'h0,
                 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    runMemAccess("sb", 32'h0000_0001, 32'h1234_5678, 2'b00, 0, 5'd0, 0, 0, 0, 1, 32'h0,
                 32'h0000_0000, 4'b0010, 32'h7878_7878, 32'h0);
    runMemAccess("lh", 32'h0000_0302, 32'h0, 2'b01, 0, 5'd11, 1, 1, 0, 1, 32'h8001_7FFF,
                 32'h0000_0300, 4'b1100, 32'h0, 32'hFFFF_8001);
    runMemAccess("lw", 32'h0000_0404, 32'h0, 2'b10, 0, 5'd12, 1, 1, 0, 0, 32'hDEAD_BEEF,
                 32'h0000_0404, 4'b1111, 32'h0, 32'hDEAD_BEEF);

    // Reset while waiting for an ack must drop the request and lose the op.
    clearInputs();
    in_valid = 1; ALU_result = 32'h0000_0300; mem_read = 1; mem_size = 2'b10;
    Rd = 5'd6; reg_write = 1;
    @(negedge clk);
    clearInputs();
    checkOutput("rstbusy req before", {31'b0, dmem_req}, 32'd1);
    #2 rst_n = 0;
    #1;
    checkOutput("rstbusy req dropped", {31'b0, dmem_req}, 32'd0);
    checkOutput("rstbusy in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1;
    dmem_ack = 1;
    dmem_rdata = 32'h1111_1111;
    @(negedge clk);
    dmem_ack = 0;
    checkOutput("rstbusy no out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rstbusy in_ready after", {31'b0, in_ready}, 32'd1);
    checkOutput("rstbusy req after", {31'b0, dmem_req}, 32'd0);
    @(negedge clk);
    checkOutput("rstbusy still no out_valid", {31'b0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline MEM stage, directly downstream of the execution stage. Takes the execute results (ALU result/address, store data, destination register, jump flag and target PC) and performs byte/half/word loads and stores over a request/acknowledge data-memory port. Resolves conditional branches into a single redirect to fetch, and registers the MEM/WB payload for writeback.

## Interface
Parameters
- none; 32-bit datapath, 5-bit register index, fixed.

Ports
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute result valid this cycle
- in_ready  out  1  stage can accept; high only in IDLE
- ALU_result  in  32  ALU output: memory address for load/store, compare result (bit 0) for branches, writeback value otherwise
- Rdata2  in  32  store data
- Rd  in  5  destination register
- PC  in  32  instruction PC
- jump_flag  in  1  JAL/JALR: unconditional redirect
- jump_target_PC  in  32  jump/branch target
- branch_op  in  1  conditional branch
- mem_read / mem_write  in  1 / 1  load / store
- mem_size  in  2  00 byte, 01 half, 10 word; 11 treated as word
- mem_unsigned  in  1  zero-extend loads (LBU/LHU)
- reg_write  in  1  instruction writes Rd
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({ALU_result[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-shifted store data
- dmem_rdata  in  32  read data, valid with dmem_ack
- dmem_ack  in  1  completes the outstanding request
- out_valid  out  1  MEM/WB payload valid, one-cycle pulse per instruction
- wb_Rd  out  5  destination register
- wb_reg_write  out  1  gated write enable
- wb_data  out  32  writeback value
- redirect_valid  out  1  one-cycle pulse: fetch must load redirect_PC
- redirect_PC  out  32  redirect target
- misalign_fault  out  1  pulse with out_valid for a misaligned access

## Operation
- FSM states: IDLE, BUSY. Reset → IDLE.
- IDLE, in_valid=1, aligned memory op (mem_read|mem_write): latch address, size, unsigned, Rd, reg_write, and store data. Compute dmem_be/dmem_wdata. Go to BUSY.
- IDLE, in_valid=1, non-memory op or misaligned op: register the payload directly. Set out_valid=1 next cycle. Stay in IDLE.
- BUSY: dmem_req=1, with address, we, be, and wdata held stable. On dmem_ack=1, capture the load result, set out_valid=1 next cycle, and return to IDLE.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00. A misaligned op issues no request, sets wb_reg_write=0, and pulses misalign_fault with out_valid.
- Byte enables: byte → 0001<<addr[1:0]; half → 0011<<addr[1:0]; word → 1111.
- Store data: byte replicated into all 4 lanes; half replicated into both halves.
- Load data: select the lane by addr[1:0], then sign- or zero-extend per mem_unsigned.
- wb_data: jump_flag → PC+4 (mod 2^32); load → extended data; otherwise ALU_result.
- wb_reg_write = reg_write & ~misalign_fault.
- Branch resolution: taken = jump_flag | (branch_op & ALU_result[0]). Taken → redirect_valid=1 with redirect_PC=jump_target_PC, both registered with the same timing as out_valid.
- A memory op with jump_flag or branch_op set is illegal input and has undefined result.

## Timing
- Reset (async, immediate) values:
  - FSM = IDLE
  - in_ready = 1
  - dmem_req, dmem_we, out_valid, redirect_valid, misalign_fault, wb_reg_write = 0
  - dmem_be = 0000
  - dmem_addr, dmem_wdata, wb_data, redirect_PC = 0
  - wb_Rd = 0
- Non-memory op accepted at edge N: out_valid (and redirect_valid if taken) high during cycle N+1 only.
- Memory op accepted at edge N: dmem_req high from N+1. Ack sampled at edge M (earliest M = N+1) → out_valid during cycle M+1. dmem_req is low in cycle M+1.
- in_ready = 0 throughout BUSY. The next instruction can be accepted at edge M+1. Back-to-back non-memory ops sustain one per cycle.
- dmem_ack outside BUSY is ignored.
- No ack timeout: BUSY waits indefinitely.
- Writeback never back-pressures.
- Reset asserted during BUSY drops dmem_req immediately and discards the operation; no out_valid is produced.

## Test plan
- ALU op: ALU_result=0x1234, Rd=5, reg_write=1 → next cycle out_valid=1, wb_data=0x1234, wb_Rd=5, wb_reg_write=1, no dmem_req.
- LB at addr 0x103 with dmem_rdata=0x80FF_FF00, ack 2 cycles after req → dmem_addr=0x100, be=1000, wb_data=0xFFFF_FF80. Same access as LBU → wb_data=0x0000_0080. in_ready=0 until the cycle after ack.
- SH at 0x202 with Rdata2=0xAAAA_BEEF, ack same cycle as first req → dmem_we=1, be=1100, wdata=0xBEEF_BEEF. out_valid=1 with wb_reg_write=0.
- LW at 0x101 → no dmem_req, out_valid=1, misalign_fault=1, wb_reg_write=0.
- Branch with ALU_result=1, jump_target_PC=0x400 → redirect_valid=1, redirect_PC=0x400. ALU_result=0 → no redirect. JAL at PC=0x80 → redirect plus wb_data=0x84.
- Reset mid-BUSY: rst_n low during the wait → dmem_req=0 at once. After release: in_ready=1 and no out_valid.
